// File: rtl/mux1_operand_stage.sv
// mux1_operand_stage
// Registered operand selector that feeds the Montgomery multiplier core.
// Each accepted transaction yields one WIDTH-bit operand: a, b, one, zero,
// the previously selected operand, or a halved. Results leave through a
// valid/ready handshake. A two-entry (main + skid) buffer lets in_ready come
// straight from a register while still sustaining one result per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream offers a, b, sel
//   in_ready   stage can accept (registered)
//   a, b       operand sources, WIDTH bits
//   sel        source select, decoded on the accept cycle
//   out_valid  out holds a result
//   out_ready  downstream takes out
//   out        selected operand (registered)
module mux1_operand_stage #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out
);

   function automatic logic [WIDTH-1:0] select_operand(
      input logic [2:0]       s,
      input logic [WIDTH-1:0] av,
      input logic [WIDTH-1:0] bv,
      input logic [WIDTH-1:0] pv
   );
      logic [WIDTH-1:0] r;
      r = '0;
      case (s)
         3'b000:  r = av;
         3'b001:  r = bv;
         3'b010:  r = WIDTH'(1);
         3'b011:  r = '0;
         3'b100:  r = pv;
         3'b101:  r = {1'b0, av[WIDTH-1:1]};
         default: r = '0;
      endcase
      return r;
   endfunction

   logic             acc;
   logic             xfer;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] skid_data;
   logic             skid_valid;

   logic             out_valid_n;
   logic [WIDTH-1:0] out_n;
   logic             skid_valid_n;
   logic [WIDTH-1:0] skid_data_n;

   assign acc    = in_valid && in_ready;
   assign xfer   = out_valid && out_ready;
   // prev is the value before this edge, so repeated sel=100 re-emits it
   assign result = select_operand(sel, a, b, prev);

   // Skid is only ever filled while main is full and drained into main
   // before main can empty, so the skid entry is always the oldest pending.
   always_comb begin
      out_valid_n  = out_valid;
      out_n        = out;
      skid_valid_n = skid_valid;
      skid_data_n  = skid_data;
      if (!out_valid) begin
         if (acc) begin
            out_valid_n = 1'b1;
            out_n       = result;
         end
      end else if (xfer) begin
         if (skid_valid) begin
            out_n        = skid_data;
            skid_valid_n = 1'b0;
         end else if (acc) begin
            out_n = result;
         end else begin
            out_valid_n = 1'b0;
         end
      end else if (acc) begin
         skid_valid_n = 1'b1;
         skid_data_n  = result;
      end
   end

   // ---- stage boundary: accept -> main/skid registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out        <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         prev       <= '0;
         in_ready   <= 1'b1;
      end else begin
         out_valid  <= out_valid_n;
         out        <= out_n;
         skid_valid <= skid_valid_n;
         skid_data  <= skid_data_n;
         if (acc) begin
            prev <= result;
         end
         in_ready   <= !skid_valid_n;
      end
   end

endmodule

// File: tb/tb_mux1_operand_stage.sv
module tb_mux1_operand_stage;

   localparam int W = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2:0]    sel;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out10;

   logic          in_valid32;
   logic          in_ready32;
   logic [31:0]   a32;
   logic [31:0]   b32;
   logic [2:0]    sel32;
   logic          out_valid32;
   logic          out_ready32;
   logic [31:0]   out32;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] sb_q[$];
   logic [W-1:0] m_prev = '0;
   bit           after_reset = 1'b0;

   always #5 clk = ~clk;

   mux1_operand_stage #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .out(out10)
   );

   mux1_operand_stage #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .sel(sel32), .out_valid(out_valid32),
      .out_ready(out_ready32), .out(out32)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference operand choice straight from the select table.
   function automatic logic [W-1:0] model(input logic [2:0] s, input logic [W-1:0] av,
                                          input logic [W-1:0] bv, input logic [W-1:0] pv);
      case (s)
         3'd0:    return av;
         3'd1:    return bv;
         3'd2:    return W'(1);
         3'd4:    return pv;
         3'd5:    return W'(av / 2);
         default: return W'(0);
      endcase
   endfunction

   // Monitor: mid-cycle, check occupancy-derived flags, then account for what
   // the coming edge will transfer and accept.
   always @(negedge clk) begin
      check("out_valid_vs_occupancy", 64'(out_valid), 64'(sb_q.size() > 0));
      check("in_ready_vs_occupancy", 64'(in_ready), 64'(sb_q.size() < 2));
      if (after_reset) check("out_after_reset", 64'(out10), 64'(0));
      if (rst) begin
         sb_q.delete();
         m_prev      = '0;
         after_reset = 1'b1;
      end else begin
         after_reset = 1'b0;
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL out_unexpected: got 0x%0h, expected no output", out10);
            end else begin
               check("out_data", 64'(out10), 64'(sb_q.pop_front()));
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(sel, a, b, m_prev));
            m_prev = model(sel, a, b, m_prev);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] s, input logic [W-1:0] av, input logic [W-1:0] bv);
      int n = 0;
      in_valid = 1'b1;
      sel = s;
      a = av;
      b = bv;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1");
      end
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b1;
      sel = 3'd0;
      a = 10'h2AB;
      b = 10'h155;
      out_ready = 1'b1;
      in_valid32 = 1'b0;
      a32 = '0;
      b32 = '0;
      sel32 = 3'd0;
      out_ready32 = 1'b1;

      // reset held two cycles with in_valid high
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      tick();

      // decode sweep
      for (int s = 0; s < 8; s++) send(3'(s), 10'h2AB, 10'h155);
      repeat (3) tick();

      // hold chain
      send(3'd1, 10'h000, 10'h3FF);
      repeat (3) send(3'd4, 10'h000, 10'h000);
      send(3'd5, 10'h3FF, 10'h000);
      repeat (3) tick();

      // back-pressure while streaming 1..8
      fork
         begin
            for (int v = 1; v <= 8; v++) send(3'd0, W'(v), 10'h000);
         end
         begin
            repeat (3) tick();
            out_ready = 1'b0;
            repeat (3) tick();
            out_ready = 1'b1;
         end
      join
      repeat (4) tick();

      // reset with main and skid both full
      out_ready = 1'b0;
      in_valid = 1'b1;
      sel = 3'd0;
      for (int i = 0; i < 10 && in_ready; i++) begin
         a = W'($urandom);
         tick();
      end
      check("stall_in_ready_low", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      rst = 1'b1;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      check("post_reset_out_valid", 64'(out_valid), 64'(0));
      check("post_reset_in_ready", 64'(in_ready), 64'(1));
      send(3'd4, 10'h3FF, 10'h3FF);
      tick();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 4) != 0;
         sel       = 3'($urandom);
         a         = W'($urandom);
         b         = W'($urandom);
         out_ready = ($urandom % 3) != 0;
         tick();
      end

      // drain
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
      check("drain_empty", 64'(sb_q.size()), 64'(0));

      // 32-bit instance
      in_valid32 = 1'b1;
      a32 = 32'hFFFF_FFFF;
      sel32 = 3'd5;
      tick();
      check("w32_valid", 64'(out_valid32), 64'(1));
      check("w32_half", 64'(out32), 64'h7FFF_FFFF);
      sel32 = 3'd2;
      tick();
      in_valid32 = 1'b0;
      check("w32_one", 64'(out32), 64'h0000_0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
